mario_motion_ctrl: RTL and testbench
====================================

// Module: mario_motion_ctrl
// PURPOSE
// Per-frame Mario state machine and position integrator. Consumes player buttons plus map/collision
// flags; produces posX/posY/state for the sprite renderer and debug overlay. Sits between input
// synchroniser and the pixel layer; all motion advances once per frame_tick (one pulse per VGA frame).
// PARAMETERS
// X_INIT       10'd60   spawn X (left edge of sprite box)
// Y_INIT       9'd390   spawn Y (top edge of sprite box)
// WALK_STEP    2        px/frame horizontal, walking or airborne
// CLIMB_STEP   1        px/frame vertical on ladder
// JUMP_V0      6        initial upward speed, px/frame
// GRAVITY      1        vy increment per frame while airborne
// MAX_FALL     8        terminal vy
// FALL_KILL    48       fall distance (px) at or above which landing kills
// DYING_FRAMES 60       frames spent in DYING before respawn
// PORTS
// clk         in   1   system clock
// rst         in   1   synchronous, active-high reset
// frame_tick  in   1   1-cycle pulse, start of vertical blank
// btn_left    in   1   level, synchronised
// btn_right   in   1   level
// btn_up      in   1   level
// btn_down    in   1   level
// btn_jump    in   1   level
// on_floor    in   1   sprite feet resting on girder (from collision map)
// on_ladder   in   1   sprite overlaps ladder column
// hit         in   1   sprite overlaps hazard (barrel/fire)
// posX        out  10  sprite X, LEFT_BOARD..RIGHT_BOARD
// posY        out  9   sprite Y, TOP_BOARD..BOTTOM_BOARD
// state       out  3   MARIO_* encoding
// dir         out  1   facing: 0 left, 1 right
// died        out  1   1-cycle pulse on entry to DYING
// BEHAVIOUR
// - Reset (rst wins over frame_tick): state=INITIAL, posX=X_INIT, posY=Y_INIT, dir=1, died=0, vy=0, counters=0.
// - Inputs sampled only in the frame_tick cycle; outputs registered, valid the following cycle, held until next tick.
// - Priority per tick: hit (state not DYING/INITIAL) -> DYING; else state transition below.
// - INITIAL: -> STANDING if on_floor else FLYING (vy=0).
// - STANDING: jump&on_floor -> JUMPING, vy=-JUMP_V0; up&on_ladder -> CLAMPING; exactly one of left/right -> WALKING,
//   dir set; !on_floor -> FLYING. Jump beats climb beats walk.
// - WALKING: posX +/- WALK_STEP; both or neither L/R -> STANDING; jump/ladder/floor rules as STANDING.
// - JUMPING: posY += vy; vy += GRAVITY; posX moves WALK_STEP in dir if that button held; vy reaching >=0 -> FLYING.
// - FLYING: posY += vy; vy = min(vy+GRAVITY, MAX_FALL); fall_dist += vy. on_floor or posY==BOTTOM_BOARD ->
//   STANDING, vy=0, but fall_dist>=FALL_KILL -> DYING. fall_dist cleared on leaving FLYING.
// - CLAMPING: up -> posY-=CLIMB_STEP, down -> posY+=CLIMB_STEP, both = hold; !on_ladder -> STANDING; L/R ignored.
// - DYING: position frozen; died pulses 1 cycle on entry; after DYING_FRAMES ticks -> INITIAL with spawn position.
// - Arithmetic: vy 5-bit signed; next X/Y computed 11-bit signed then saturated to LEFT/RIGHT_BOARD, TOP/BOTTOM_BOARD.
//   Hitting TOP_BOARD in JUMPING forces vy=0 (-> FLYING next tick). No wrap-around permitted.
// STRUCTURE
// - Shared package: MARIO_* state codes (INITIAL 000, FLYING 001, JUMPING 010, WALKING 011, STANDING 100,
//   DYING 101, CLAMPING 110), TOP/BOTTOM/LEFT/RIGHT_BOARD (50/430/50/590).
// - One sub-module: mario_axis_step (combinational signed add + saturate), instantiated for X and Y.
// TESTING
// - rst high across a frame_tick -> posX=60,posY=390,state=000; release, tick with on_floor=1 -> state=100.
// - STANDING, btn_right held 10 ticks -> state=011, posX=80, dir=1; release -> state=100 next tick.
// - Jump from posY=390, on_floor=0 after launch -> posY 384,379,375,372,370,369,369 then state=001, descending.
// - FLYING from posY=300 to floor at 360 (60px) -> state=101, died one pulse, after 60 ticks state=000, spawn pos.
// - posX=51, btn_left held -> posX saturates at 50, stays 50; likewise posY saturates at 430.
// - hit and btn_jump same tick in WALKING -> DYING, no jump; rst during DYING -> INITIAL immediately.

Source files
------------

// File: rtl/mario_motion_ctrl_pkg.sv
// Shared types and tuning constants for Mario motion control.
// State codes match the sprite renderer and debug overlay.
package mario_motion_ctrl_pkg;

  typedef enum logic [2:0] {
    MARIO_INITIAL  = 3'b000,
    MARIO_FLYING   = 3'b001,
    MARIO_JUMPING  = 3'b010,
    MARIO_WALKING  = 3'b011,
    MARIO_STANDING = 3'b100,
    MARIO_DYING    = 3'b101,
    MARIO_CLAMPING = 3'b110
  } mario_state_t;

  localparam int TOP_BOARD    = 50;
  localparam int BOTTOM_BOARD = 430;
  localparam int LEFT_BOARD   = 50;
  localparam int RIGHT_BOARD  = 590;

  localparam logic [9:0] X_INIT = 10'd60;
  localparam logic [8:0] Y_INIT = 9'd390;

  localparam logic signed [4:0] WALK_STEP  = 5'sd2;
  localparam logic signed [4:0] CLIMB_STEP = 5'sd1;
  localparam logic signed [4:0] JUMP_V0    = 5'sd6;
  localparam logic signed [4:0] GRAVITY    = 5'sd1;
  localparam logic signed [4:0] MAX_FALL   = 5'sd8;

  localparam logic [9:0] FALL_KILL    = 10'd48;
  localparam int         DYING_FRAMES = 60;
  localparam logic [5:0] DIE_LAST     = 6'(DYING_FRAMES - 1);

endpackage

// File: rtl/mario_motion_ctrl_if.sv
// Player/collision inputs and sprite outputs of the motion block.
// master drives the inputs, slave is the motion controller.
interface mario_motion_ctrl_if;
  import mario_motion_ctrl_pkg::*;

  logic         frame_tick;
  logic         btn_left;
  logic         btn_right;
  logic         btn_up;
  logic         btn_down;
  logic         btn_jump;
  logic         on_floor;
  logic         on_ladder;
  logic         hit;
  logic [9:0]   posX;
  logic [8:0]   posY;
  mario_state_t state;
  logic         dir;
  logic         died;

  modport master (
    output frame_tick, btn_left, btn_right,
    output btn_up, btn_down, btn_jump,
    output on_floor, on_ladder, hit,
    input  posX, posY, state, dir, died
  );

  modport slave (
    input  frame_tick, btn_left, btn_right,
    input  btn_up, btn_down, btn_jump,
    input  on_floor, on_ladder, hit,
    output posX, posY, state, dir, died
  );

endinterface

// File: rtl/mario_axis_step.sv
// One-axis position step: signed add in 11 bits, then clamp
// to the board edges so the sprite never wraps.
module mario_axis_step #(
  parameter int W  = 10,
  parameter int LO = 0,
  parameter int HI = 1023
) (
  input  logic [W-1:0]      pos,
  input  logic signed [4:0] delta,
  output logic [W-1:0]      next
);

  logic signed [10:0] sum;

  always_comb begin
    sum = $signed(11'(pos)) + 11'(delta);
    if (sum < 11'(LO))
      next = W'(LO);
    else if (sum > 11'(HI))
      next = W'(HI);
    else
      next = W'(sum);
  end

endmodule

// File: rtl/mario_motion_ctrl.sv
// Per-frame Mario state machine and position integrator.
// All motion advances only in frame_tick cycles.
module mario_motion_ctrl
  import mario_motion_ctrl_pkg::*;
(
  input logic clk,
  input logic rst,
  mario_motion_ctrl_if.slave bus
);

  mario_state_t      st;
  logic [9:0]        pos_x;
  logic [8:0]        pos_y;
  logic              dir_q;
  logic              died_q;
  logic signed [4:0] vy;
  logic signed [4:0] vy_inc;
  logic [9:0]        fall;
  logic [5:0]        die_cnt;
  logic signed [4:0] dx;
  logic signed [4:0] dy;
  logic [9:0]        nx;
  logic [8:0]        ny;
  logic              walk_one;
  logic              air_move;
  logic              launch;
  logic              grab;
  logic              land;

  assign walk_one = bus.btn_left ^ bus.btn_right;
  assign air_move = dir_q ? bus.btn_right : bus.btn_left;
  assign launch   = bus.btn_jump & bus.on_floor;
  assign grab     = bus.btn_up & bus.on_ladder;
  assign land     = bus.on_floor | (pos_y == 9'(BOTTOM_BOARD));
  assign vy_inc   = vy + GRAVITY;

  always_comb begin
    dx = '0;
    dy = '0;
    unique case (st)
      MARIO_STANDING, MARIO_WALKING: begin
        if (walk_one)
          dx = bus.btn_right ? WALK_STEP : -WALK_STEP;
      end
      MARIO_JUMPING, MARIO_FLYING: begin
        dy = vy;
        if (air_move)
          dx = dir_q ? WALK_STEP : -WALK_STEP;
      end
      MARIO_CLAMPING: begin
        unique case (1'b1)
          bus.btn_up & ~bus.btn_down: dy = -CLIMB_STEP;
          bus.btn_down & ~bus.btn_up: dy = CLIMB_STEP;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  mario_axis_step #(
    .W(10), .LO(LEFT_BOARD), .HI(RIGHT_BOARD)
  ) u_step_x (
    .pos(pos_x), .delta(dx), .next(nx)
  );

  mario_axis_step #(
    .W(9), .LO(TOP_BOARD), .HI(BOTTOM_BOARD)
  ) u_step_y (
    .pos(pos_y), .delta(dy), .next(ny)
  );

  always_ff @(posedge clk) begin
    died_q <= 1'b0;
    if (rst) begin
      st      <= MARIO_INITIAL;
      pos_x   <= X_INIT;
      pos_y   <= Y_INIT;
      dir_q   <= 1'b1;
      vy      <= '0;
      fall    <= '0;
      die_cnt <= '0;
    end else if (bus.frame_tick) begin
      if (bus.hit && st != MARIO_DYING
          && st != MARIO_INITIAL) begin
        st      <= MARIO_DYING;
        died_q  <= 1'b1;
        vy      <= '0;
        fall    <= '0;
        die_cnt <= '0;
      end else begin
        unique case (st)
          MARIO_INITIAL: begin
            st <= bus.on_floor ? MARIO_STANDING : MARIO_FLYING;
            vy <= '0;
          end
          MARIO_STANDING, MARIO_WALKING: begin
            if (launch) begin
              st <= MARIO_JUMPING;
              vy <= -JUMP_V0;
            end else if (grab) begin
              st <= MARIO_CLAMPING;
            end else if (!bus.on_floor) begin
              st <= MARIO_FLYING;
              vy <= '0;
            end else if (walk_one) begin
              st    <= MARIO_WALKING;
              dir_q <= bus.btn_right;
              pos_x <= nx;
            end else begin
              st <= MARIO_STANDING;
            end
          end
          MARIO_JUMPING: begin
            pos_x <= nx;
            pos_y <= ny;
            // Bumping the ceiling kills upward speed at once.
            vy <= (ny == 9'(TOP_BOARD)) ? '0 : vy_inc;
            if (ny == 9'(TOP_BOARD) || !vy_inc[4])
              st <= MARIO_FLYING;
          end
          MARIO_FLYING: begin
            if (land) begin
              vy   <= '0;
              fall <= '0;
              if (fall >= FALL_KILL) begin
                st      <= MARIO_DYING;
                died_q  <= 1'b1;
                die_cnt <= '0;
              end else begin
                st <= MARIO_STANDING;
              end
            end else begin
              pos_x <= nx;
              pos_y <= ny;
              vy    <= (vy_inc > MAX_FALL) ? MAX_FALL : vy_inc;
              fall  <= fall + 10'(ny) - 10'(pos_y);
            end
          end
          MARIO_CLAMPING: begin
            if (!bus.on_ladder)
              st <= MARIO_STANDING;
            else
              pos_y <= ny;
          end
          MARIO_DYING: begin
            if (die_cnt == DIE_LAST) begin
              st      <= MARIO_INITIAL;
              pos_x   <= X_INIT;
              pos_y   <= Y_INIT;
              die_cnt <= '0;
            end else begin
              die_cnt <= die_cnt + 6'd1;
            end
          end
          default: st <= MARIO_INITIAL;
        endcase
      end
    end
  end

  assign bus.posX  = pos_x;
  assign bus.posY  = pos_y;
  assign bus.state = st;
  assign bus.dir   = dir_q;
  assign bus.died  = died_q;

endmodule

// File: tb/tb_mario_motion_ctrl.sv
// Scoreboard bench: driver queues hand-computed expectations per
// frame tick, monitor compares the registered outputs afterwards.
module tb_mario_motion_ctrl;
  import mario_motion_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mario_motion_ctrl_if bus();

  mario_motion_ctrl dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [4:0] m;
    int x;
    int y;
    int s;
    int d;
    int dd;
    string nm;
  } exp_t;

  localparam logic [4:0] MX = 5'd1;
  localparam logic [4:0] MY = 5'd2;
  localparam logic [4:0] MS = 5'd4;
  localparam logic [4:0] MD = 5'd8;
  localparam logic [4:0] MK = 5'd16;
  localparam logic [4:0] MA = 5'd31;

  localparam logic [4:0] B0 = 5'b00000;
  localparam logic [4:0] BL = 5'b10000;
  localparam logic [4:0] BR = 5'b01000;
  localparam logic [4:0] BU = 5'b00100;
  localparam logic [4:0] BD = 5'b00010;
  localparam logic [4:0] BJ = 5'b00001;

  localparam logic [2:0] F0 = 3'b000;
  localparam logic [2:0] FF = 3'b100;
  localparam logic [2:0] FL = 3'b010;
  localparam logic [2:0] FH = 3'b001;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic exp_t mk(logic [4:0] m, int x, int y,
                              int s, int d, int dd, string nm);
    exp_t e;
    e.m = m; e.x = x; e.y = y; e.s = s;
    e.d = d; e.dd = dd; e.nm = nm;
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic tick(input logic [4:0] b, input logic [2:0] f,
                      input logic r, input exp_t e);
    @(negedge clk);
    {bus.btn_left, bus.btn_right, bus.btn_up,
     bus.btn_down, bus.btn_jump} = b;
    {bus.on_floor, bus.on_ladder, bus.hit} = f;
    rst = r;
    bus.frame_tick = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    bus.frame_tick = 1'b0;
    rst = 1'b0;
  endtask

  // Monitor: outputs are valid in the cycle after each tick.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (bus.frame_tick === 1'b1) begin
        @(negedge clk);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty actual=0 expected=1");
        end else begin
          e = sb.pop_front();
          if (e.m[0]) check({e.nm, "_x"}, 32'(bus.posX), e.x);
          if (e.m[1]) check({e.nm, "_y"}, 32'(bus.posY), e.y);
          if (e.m[2]) check({e.nm, "_st"}, 32'(bus.state), e.s);
          if (e.m[3]) check({e.nm, "_dir"}, 32'(bus.dir), e.d);
          if (e.m[4]) check({e.nm, "_died"}, 32'(bus.died), e.dd);
          if (e.m[4] && e.dd == 1) begin
            @(negedge clk);
            check({e.nm, "_died_w"}, 32'(bus.died), 0);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int yv;
    int ys[$];
    rst = 1'b1;
    bus.frame_tick = 1'b0;
    {bus.btn_left, bus.btn_right, bus.btn_up,
     bus.btn_down, bus.btn_jump} = B0;
    {bus.on_floor, bus.on_ladder, bus.hit} = F0;
    repeat (3) @(negedge clk);

    tick(B0, FF, 1'b1, mk(MA, 60, 390, 0, 1, 0, "reset"));
    tick(B0, FF, 1'b0, mk(MA, 60, 390, 4, 1, 0, "init_floor"));

    for (int i = 1; i <= 10; i++)
      tick(BR, FF, 1'b0, mk(MX | MS | MD, 60 + 2 * i, 0, 3, 1, 0,
           $sformatf("walk_r%0d", i)));
    tick(B0, FF, 1'b0, mk(MX | MS, 80, 0, 4, 0, 0, "stop_r"));

    for (int i = 1; i <= 15; i++) begin
      yv = 80 - 2 * i;
      if (yv < 50) yv = 50;
      tick(BL, FF, 1'b0, mk(MX | MS | MD, yv, 0, 3, 0, 0,
           $sformatf("walk_l%0d", i)));
    end
    tick(BL | BR, FF, 1'b0, mk(MX | MS, 50, 0, 4, 0, 0, "both_lr"));

    tick(BJ, FF, 1'b0, mk(MY | MS, 0, 390, 2, 0, 0, "launch"));
    ys = '{384, 379, 375, 372, 370, 369};
    foreach (ys[i])
      tick(B0, F0, 1'b0, mk(MY | MS, 0, ys[i], (i == 5) ? 1 : 2, 0, 0,
           $sformatf("jump%0d", i)));
    ys = '{369, 370, 372, 375, 379, 384, 390};
    foreach (ys[i])
      tick(B0, F0, 1'b0, mk(MY | MS, 0, ys[i], 1, 0, 0,
           $sformatf("desc%0d", i)));
    tick(B0, FF, 1'b0, mk(MY | MS | MK, 0, 390, 4, 0, 0, "land390"));

    tick(B0, F0, 1'b0, mk(MY | MS, 0, 390, 1, 0, 0, "walk_off"));
    ys = '{390, 391, 393, 396, 400, 405, 411, 418, 426, 430};
    foreach (ys[i])
      tick(B0, F0, 1'b0, mk(MY | MS, 0, ys[i], 1, 0, 0,
           $sformatf("fall%0d", i)));
    tick(B0, F0, 1'b0, mk(MY | MS | MK, 0, 430, 4, 0, 0, "land_bottom"));

    tick(BU, FF | FL, 1'b0, mk(MY | MS, 0, 430, 6, 0, 0, "grab"));
    for (int i = 1; i <= 130; i++)
      tick(BU, FL, 1'b0, mk(MY | MS, 0, 430 - i, 6, 0, 0,
           $sformatf("climb%0d", i)));
    tick(BU | BD, FL, 1'b0, mk(MY | MS, 0, 300, 6, 0, 0, "climb_hold"));
    tick(BL, FL, 1'b0, mk(MX | MY | MS, 50, 300, 6, 0, 0, "climb_lr"));
    tick(B0, F0, 1'b0, mk(MY | MS, 0, 300, 4, 0, 0, "off_ladder"));
    tick(B0, F0, 1'b0, mk(MY | MS, 0, 300, 1, 0, 0, "drop"));
    ys = '{300, 301, 303, 306, 310, 315, 321, 328, 336, 344, 352, 360};
    foreach (ys[i])
      tick(B0, F0, 1'b0, mk(MY | MS, 0, ys[i], 1, 0, 0,
           $sformatf("drop%0d", i)));
    tick(B0, FF, 1'b0, mk(MA, 50, 360, 5, 0, 1, "fall_kill"));

    for (int i = 1; i <= 59; i++)
      tick(B0, (i == 1) ? FH : F0, 1'b0,
           mk(MX | MY | MS | MK, 50, 360, 5, 0, 0,
              $sformatf("dying%0d", i)));
    tick(B0, F0, 1'b0, mk(MX | MY | MS, 60, 390, 0, 0, 0, "respawn"));
    tick(B0, FF | FH, 1'b0, mk(MS | MK, 0, 0, 4, 0, 0, "init_hit"));

    tick(BR, FF, 1'b0, mk(MX | MS | MD, 62, 0, 3, 1, 0, "walk_again"));
    tick(BR | BJ, FF | FH, 1'b0, mk(MA, 62, 390, 5, 1, 1, "hit_jump"));
    tick(BJ, FF, 1'b0, mk(MX | MY | MS, 62, 390, 5, 0, 0, "dying_a"));
    tick(BJ, FF, 1'b1, mk(MA, 60, 390, 0, 1, 0, "rst_dying"));

    tick(B0, FF, 1'b0, mk(MS, 0, 0, 4, 0, 0, "top_stand"));
    tick(BU, FF | FL, 1'b0, mk(MS, 0, 0, 6, 0, 0, "top_grab"));
    for (int i = 1; i <= 337; i++)
      tick(BU, FL, 1'b0, mk((i == 337) ? MY : 5'd0, 0, 53, 0, 0, 0,
           "top_climb"));
    tick(B0, FF, 1'b0, mk(MY | MS, 0, 53, 4, 0, 0, "top_off"));
    tick(BJ, FF, 1'b0, mk(MY | MS, 0, 53, 2, 0, 0, "top_launch"));
    tick(B0, F0, 1'b0, mk(MX | MY | MS, 60, 50, 1, 0, 0, "top_bump"));
    tick(B0, F0, 1'b0, mk(MY | MS, 0, 50, 1, 0, 0, "top_fall0"));
    tick(B0, F0, 1'b0, mk(MY | MS, 0, 51, 1, 0, 0, "top_fall1"));

    repeat (4) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
